// File: rtl/mul_seq_arbiter.sv
// Round-robin sequencer that shares one repeated-addition multiplier datapath
// among N_REQ requesters: captures the winner's operands, steps the datapath
// through load/add phases and returns the product with a one-cycle done pulse.
module mul_seq_arbiter #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   a_in,
   input  logic [N_REQ*WIDTH-1:0]   b_in,
   output logic [N_REQ-1:0]         grant,
   output logic [N_REQ-1:0]         done,
   output logic [WIDTH-1:0]         result,
   output logic [WIDTH-1:0]         data_in,
   output logic                     LdA,
   output logic                     LdB,
   output logic                     LdP,
   output logic                     clrP,
   output logic                     decB,
   input  logic                     eqz,
   input  logic [WIDTH-1:0]         prod
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOADA = 2'd1,
      LOADB = 2'd2,
      ADD   = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [IDX_W-1:0]    ptr;
   logic [IDX_W-1:0]    owner;
   logic [IDX_W-1:0]    win_idx;
   logic                win_vld;
   logic [WIDTH-1:0]    op_a;
   logic [WIDTH-1:0]    op_b;
   logic [WIDTH-1:0]    a_sl [N_REQ];
   logic [WIDTH-1:0]    b_sl [N_REQ];

   // (base + off) mod N_REQ, valid for off < N_REQ
   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int unsigned      off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= N_REQ) begin
         s = s - N_REQ;
      end
      return IDX_W'(s);
   endfunction

   // Split the flat operand buses into per-requester slices
   for (genvar g = 0; g < N_REQ; g++) begin : g_slice
      assign a_sl[g] = a_in[g*WIDTH +: WIDTH];
      assign b_sl[g] = b_in[g*WIDTH +: WIDTH];
   end

   // Round-robin pick: first active request at or above the pointer, with wrap
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (!win_vld && req[wrap_idx(ptr, k)]) begin
            win_vld = 1'b1;
            win_idx = wrap_idx(ptr, k);
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and datapath strobes decoded from the current state (+eqz in ADD)
   always_comb begin
      state_nxt = state;
      data_in   = '0;
      LdA       = 1'b0;
      LdB       = 1'b0;
      LdP       = 1'b0;
      clrP      = 1'b0;
      decB      = 1'b0;
      case (state)
         IDLE: begin
            if (win_vld) begin
               state_nxt = LOADA;
            end
         end
         LOADA: begin
            data_in   = op_a;
            LdA       = 1'b1;
            state_nxt = LOADB;
         end
         LOADB: begin
            data_in   = op_b;
            LdB       = 1'b1;
            clrP      = 1'b1;
            state_nxt = ADD;
         end
         ADD: begin
            if (!eqz) begin
               LdP  = 1'b1;
               decB = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Grant/operand capture on acceptance; result, done pulse and pointer advance on completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant  <= '0;
         done   <= '0;
         result <= '0;
         ptr    <= '0;
         owner  <= '0;
         op_a   <= '0;
         op_b   <= '0;
      end else begin
         done <= '0;
         if (state == IDLE && win_vld) begin
            grant <= N_REQ'(1) << win_idx;
            owner <= win_idx;
            op_a  <= a_sl[win_idx];
            op_b  <= b_sl[win_idx];
         end
         if (state == ADD && eqz) begin
            result <= prod;
            done   <= grant;
            grant  <= '0;
            ptr    <= wrap_idx(owner, 1);
         end
      end
   end

endmodule

// File: tb/tb_mul_seq_arbiter.sv
// Bench for mul_seq_arbiter: behavioural repeated-addition datapath, table of
// single operations, hand sequences for round-robin hold and mid-op reset.
module tb_mul_seq_arbiter;

   localparam int unsigned N_REQ = 2;
   localparam int unsigned WIDTH = 16;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] a_in;
   logic [N_REQ*WIDTH-1:0] b_in;
   logic [N_REQ-1:0]       grant;
   logic [N_REQ-1:0]       done;
   logic [WIDTH-1:0]       result;
   logic [WIDTH-1:0]       data_in;
   logic                   LdA, LdB, LdP, clrP, decB;
   logic                   eqz;
   logic [WIDTH-1:0]       prod;

   logic [WIDTH-1:0]       dp_a = '0;
   logic [WIDTH-1:0]       dp_b = '0;
   logic [WIDTH-1:0]       dp_p = '0;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;
   int unsigned done_cnt = 0;
   int unsigned grant_cyc = 0;
   int unsigned ldp_cnt = 0;
   logic [N_REQ-1:0] prev_grant = '0;

   typedef struct {
      logic [1:0]  req;
      logic [15:0] a0, b0, a1, b1;
      logic [1:0]  exp_grant;
      logic [15:0] exp_result;
      logic        scramble;
   } vec_t;

   typedef struct {
      logic [1:0]  grant;
      logic [15:0] result;
      int unsigned b;
   } sb_t;

   sb_t  sb_q[$];
   sb_t  sb_e;
   vec_t vecs[7];

   mul_seq_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
      .grant(grant), .done(done), .result(result), .data_in(data_in),
      .LdA(LdA), .LdB(LdB), .LdP(LdP), .clrP(clrP), .decB(decB),
      .eqz(eqz), .prod(prod)
   );

   always #5 clk = ~clk;

   // Datapath: A/B/P registers, truncating adder, B decrement
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (LdA) dp_a <= data_in;
      if (LdB) dp_b <= data_in;
      else if (decB) dp_b <= dp_b - 16'd1;
      if (clrP) dp_p <= '0;
      else if (LdP) dp_p <= dp_p + dp_a;
   end
   assign eqz  = (dp_b == '0);
   assign prod = dp_p;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Monitor: on every done pulse pop the scoreboard and check owner, product, latency, add count
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (grant != '0 && prev_grant == '0) begin
            grant_cyc = cyc;
            ldp_cnt   = 0;
         end
         if (LdP) ldp_cnt++;
         if (done != '0) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               sb_e = sb_q.pop_front();
               chk("done_owner", 32'(done), 32'(sb_e.grant));
               chk("result", 32'(result), 32'(sb_e.result));
               chk("latency", cyc - grant_cyc, sb_e.b + 3);
               chk("ldp_cycles", ldp_cnt, sb_e.b);
            end
         end
      end
      prev_grant = grant;
   end

   task automatic run_vec(input vec_t v, input string tag);
      int n;
      int unsigned d0;
      d0   = done_cnt;
      a_in = {v.a1, v.a0};
      b_in = {v.b1, v.b0};
      req  = v.req;
      sb_q.push_back('{grant: v.exp_grant, result: v.exp_result,
                       b: (v.exp_grant == 2'b01) ? 32'(v.b0) : 32'(v.b1)});
      n = 0;
      while (grant == '0 && n < 20) begin @(negedge clk); n++; end
      chk({tag, "_grant"}, 32'(grant), 32'(v.exp_grant));
      if (v.scramble) begin
         @(negedge clk);
         a_in = ~a_in;
         b_in = 32'h0009_0009;
      end
      req = '0;
      n = 0;
      while (done_cnt == d0 && n < 400) begin @(negedge clk); n++; end
      chk({tag, "_done_seen"}, done_cnt - d0, 32'd1);
      if (done_cnt == d0) sb_q.delete();
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int unsigned d0;
      int unsigned rises;
      logic [1:0] pg;
      vec_t post;

      vecs[0] = '{2'b01, 16'd17,    16'd5,   16'd0,     16'd0, 2'b01, 16'd85,    1'b0};
      vecs[1] = '{2'b10, 16'd0,     16'd0,   16'd9,     16'd0, 2'b10, 16'd0,     1'b0};
      vecs[2] = '{2'b11, 16'd3,     16'd1,   16'd5,     16'd2, 2'b01, 16'd3,     1'b0};
      vecs[3] = '{2'b11, 16'd6,     16'd7,   16'd11,    16'd4, 2'b10, 16'd44,    1'b0};
      vecs[4] = '{2'b01, 16'd300,   16'd300, 16'd0,     16'd0, 2'b01, 16'd24464, 1'b0};
      vecs[5] = '{2'b10, 16'd0,     16'd0,   16'd65535, 16'd2, 2'b10, 16'd65534, 1'b0};
      vecs[6] = '{2'b01, 16'd1234,  16'd3,   16'd0,     16'd0, 2'b01, 16'd3702,  1'b1};

      rst_n = 1'b0;
      req   = '0;
      a_in  = '0;
      b_in  = '0;
      repeat (3) @(negedge clk);
      chk("rst_grant",   32'(grant), 32'd0);
      chk("rst_done",    32'(done), 32'd0);
      chk("rst_result",  32'(result), 32'd0);
      chk("rst_data_in", 32'(data_in), 32'd0);
      chk("rst_strobes", 32'({LdA, LdB, LdP, clrP, decB}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Both requests held: pointer alternates owners
      d0 = done_cnt;
      sb_q.push_back('{grant: 2'b01, result: 16'd6,  b: 2});
      sb_q.push_back('{grant: 2'b10, result: 16'd12, b: 3});
      sb_q.push_back('{grant: 2'b01, result: 16'd6,  b: 2});
      sb_q.push_back('{grant: 2'b10, result: 16'd12, b: 3});
      a_in  = {16'd4, 16'd3};
      b_in  = {16'd3, 16'd2};
      req   = 2'b11;
      rises = 0;
      n     = 0;
      pg    = grant;
      while (rises < 4 && n < 200) begin
         @(negedge clk);
         n++;
         if (grant != '0 && pg == '0) begin
            rises++;
            chk($sformatf("rr_grant%0d", rises), 32'(grant),
                (rises % 2 == 1) ? 32'd1 : 32'd2);
         end
         pg = grant;
      end
      req = '0;
      n = 0;
      while (done_cnt - d0 < 4 && n < 200) begin @(negedge clk); n++; end
      chk("rr_done_count", done_cnt - d0, 32'd4);
      if (done_cnt - d0 < 4) sb_q.delete();
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset in the middle of an ADD phase abandons the op
      d0   = done_cnt;
      a_in = {16'd0, 16'd7};
      b_in = {16'd0, 16'd10};
      req  = 2'b01;
      n = 0;
      while (grant == '0 && n < 20) begin @(negedge clk); n++; end
      chk("t5_grant", 32'(grant), 32'd1);
      req = '0;
      repeat (3) @(negedge clk);
      chk("t5_in_add_ldp", 32'(LdP), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_grant",   32'(grant), 32'd0);
      chk("t5_rst_done",    32'(done), 32'd0);
      chk("t5_rst_result",  32'(result), 32'd0);
      chk("t5_rst_data_in", 32'(data_in), 32'd0);
      chk("t5_rst_strobes", 32'({LdA, LdB, LdP, clrP, decB}), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_no_done", done_cnt - d0, 32'd0);
      post = '{2'b11, 16'd8, 16'd3, 16'd13, 16'd2, 2'b01, 16'd24, 1'b0};
      run_vec(post, "t5_after");

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
